writeback: RTL and testbench

//  Final stage of the Y86-64 pipeline; consumes the W pipeline register produced by the memory stage.

---
 rtl/writeback.sv | 135 +++++++++++++
 tb/tb_writeback.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Y86-64 writeback stage: register file with write-through bypass and a sticky status FSM.
// Optional retired-instruction counter is enabled by defining WB_RETIRE_CNT_EN.
module writeback #(
  parameter int unsigned        WIDTH    = 64,
  parameter int unsigned        NREG     = 15,
  parameter logic [WIDTH-1:0]   RSP_INIT = 64'd256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       W_icode,
  input  logic [WIDTH-1:0] W_valE,
  input  logic [WIDTH-1:0] W_valM,
  input  logic [3:0]       W_dstE,
  input  logic [3:0]       W_dstM,
  input  logic [1:0]       W_stat,
  input  logic             W_stall,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [WIDTH-1:0] d_rvalA,
  output logic [WIDTH-1:0] d_rvalB,
  output logic [1:0]       prog_stat,
  output logic             halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [WIDTH-1:0] retired
`endif
);

  // state | meaning
  // RUN   | executing, commits allowed
  // HALT  | hlt retired, sticky until rst
  // ERR   | ADR/INS fault retired, sticky until rst
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam int unsigned RSP_ID  = 4;

  state_t           state_q, state_d;
  logic [1:0]       stat_q, stat_d;
  logic             commit_en;
  logic [WIDTH-1:0] regs [NREG];

  assign commit_en = (state_q == RUN) && (W_stat == STAT_AOK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    case (state_q)
      RUN: begin
        if (W_stat == STAT_HLT) begin
          state_d = HALT;
          stat_d  = STAT_HLT;
        end else if (W_stat != STAT_AOK) begin
          state_d = ERR;
          stat_d  = W_stat;
        end
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: begin
        state_d = ERR;
        stat_d  = stat_q;
      end
    endcase
  end

  assign prog_stat = stat_q;
  assign halted    = (state_q != RUN);

  // E-port is written first so a same-register M-port write overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == RSP_ID) ? RSP_INIT : '0;
      end
    end else if (commit_en) begin
      if (W_dstE != RNONE) regs[W_dstE] <= W_valE;
      if (W_dstM != RNONE) regs[W_dstM] <= W_valM;
    end
  end

  always_comb begin
    d_rvalA = '0;
    if (d_srcA != RNONE) begin
      if (commit_en && (d_srcA == W_dstM))      d_rvalA = W_valM;
      else if (commit_en && (d_srcA == W_dstE)) d_rvalA = W_valE;
      else                                      d_rvalA = regs[d_srcA];
    end
  end

  always_comb begin
    d_rvalB = '0;
    if (d_srcB != RNONE) begin
      if (commit_en && (d_srcB == W_dstM))      d_rvalB = W_valM;
      else if (commit_en && (d_srcB == W_dstE)) d_rvalB = W_valE;
      else                                      d_rvalB = regs[d_srcB];
    end
  end

`ifdef WB_RETIRE_CNT_EN
  localparam logic [3:0] ICODE_NOP = 4'd1;

  logic [WIDTH-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (commit_en && !W_stall && (W_icode != ICODE_NOP)) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired = retired_q;
`else
  logic unused_retire_inputs;
  assign unused_retire_inputs = ^{W_icode, W_stall};
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: vector table for the status FSM, bypass and reset,
// followed by a full register-file write/read sweep.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [1:0]  W_stat;
  logic        W_stall;
  logic [3:0]  d_srcA, d_srcB;
  logic [63:0] d_rvalA, d_rvalB;
  logic [1:0]  prog_stat;
  logic        halted;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback dut (
    .clk       (clk),
    .rst       (rst),
    .W_icode   (W_icode),
    .W_valE    (W_valE),
    .W_valM    (W_valM),
    .W_dstE    (W_dstE),
    .W_dstM    (W_dstM),
    .W_stat    (W_stat),
    .W_stall   (W_stall),
    .d_srcA    (d_srcA),
    .d_srcB    (d_srcB),
    .d_rvalA   (d_rvalA),
    .d_rvalB   (d_rvalB),
    .prog_stat (prog_stat),
    .halted    (halted)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  typedef struct {
    logic        chk;
    logic        rst;
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        stall;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] eA;
    logic [63:0] eB;
    logic [1:0]  eps;
    logic        eh;
    logic [63:0] eret;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic add(input logic chk, input logic r, input logic [1:0] st, input logic [3:0] ic,
                     input logic sl, input logic [3:0] de, input logic [63:0] ve,
                     input logic [3:0] dm, input logic [63:0] vm, input logic [3:0] sa,
                     input logic [3:0] sb, input logic [63:0] ea, input logic [63:0] eb,
                     input logic [1:0] ep, input logic eh, input logic [63:0] er);
    vec_t v;
    v = '{chk, r, st, ic, sl, de, ve, dm, vm, sa, sb, ea, eb, ep, eh, er};
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; W_stat = v.stat; W_icode = v.icode; W_stall = v.stall;
    W_dstE = v.dstE; W_valE = v.valE; W_dstM = v.dstM; W_valM = v.valM;
    d_srcA = v.srcA; d_srcB = v.srcB;
  endtask

  localparam logic [3:0] F = 4'hF;

  initial begin
    rst = 1'b1; W_stat = 2'd0; W_icode = 4'd1; W_stall = 1'b0;
    W_dstE = F; W_valE = '0; W_dstM = F; W_valM = '0; d_srcA = F; d_srcB = F;

    //   chk rst st  ic sl dstE valE  dstM valM srcA srcB eA    eB   ps h  ret
    add(0, 1, 0, 1, 0, F, 0,    F, 0,   4, 0,   0,    0,   0, 0, 0);  // reset
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   4, 0,   256,  0,   0, 0, 0);
    add(1, 0, 0, 6, 0, 3, 24,   F, 0,   3, F,   24,   0,   0, 0, 0);  // E bypass
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   3, 4,   24,   256, 0, 0, 1);
    add(1, 0, 0, 11,0, 4, 1200, 4, 15,  4, 4,   15,   15,  0, 0, 1);  // M wins
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   4, 3,   15,   24,  0, 0, 2);
    add(1, 0, 0, 5, 0, 5, 100,  6, 200, 5, 6,   100,  200, 0, 0, 2);
    add(1, 0, 0, 5, 1, 5, 100,  6, 200, 5, 6,   100,  200, 0, 0, 3);  // stalled repeat
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   5, 6,   100,  200, 0, 0, 3);
    add(1, 0, 1, 0, 0, 2, 7,    F, 0,   2, F,   0,    0,   0, 0, 3);  // hlt
    add(1, 0, 0, 6, 0, 2, 9,    F, 0,   2, F,   0,    0,   1, 1, 3);
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   2, 3,   0,    24,  1, 1, 3);
    add(1, 1, 0, 1, 0, F, 0,    F, 0,   4, 3,   15,   24,  1, 1, 3);
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   4, 3,   256,  0,   0, 0, 0);
    add(1, 0, 2, 5, 0, 1, 55,   F, 0,   1, F,   0,    0,   0, 0, 0);  // ADR
    add(1, 0, 0, 6, 0, 1, 66,   F, 0,   1, F,   0,    0,   2, 1, 0);
    add(1, 1, 0, 1, 0, F, 0,    F, 0,   1, 4,   0,    256, 2, 1, 0);
    add(1, 0, 0, 6, 0, 1, 77,   F, 0,   1, F,   77,   0,   0, 0, 0);
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   1, 1,   77,   77,  0, 0, 1);
    add(1, 0, 3, 1, 0, F, 0,    F, 0,   1, F,   77,   0,   0, 0, 1);  // INS
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   1, F,   77,   0,   3, 1, 1);
    add(1, 1, 0, 6, 0, 7, 123,  F, 0,   7, F,   0,    0,   3, 1, 1);
    add(1, 1, 0, 6, 0, 7, 124,  F, 0,   7, F,   124,  0,   0, 0, 0);  // rst beats commit
    add(1, 0, 0, 1, 0, F, 0,    F, 0,   7, F,   0,    0,   0, 0, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      #3;
      if (vecs[i].chk) begin
        check($sformatf("v%0d rvalA", i), d_rvalA, vecs[i].eA);
        check($sformatf("v%0d rvalB", i), d_rvalB, vecs[i].eB);
        check($sformatf("v%0d prog_stat", i), {62'd0, prog_stat}, {62'd0, vecs[i].eps});
        check($sformatf("v%0d halted", i), {63'd0, halted}, {63'd0, vecs[i].eh});
`ifdef WB_RETIRE_CNT_EN
        check($sformatf("v%0d retired", i), retired, vecs[i].eret);
`endif
      end
    end

    // Fill every register through the M port, then read all back in pairs.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0; W_stat = 2'd0; W_icode = 4'd5; W_stall = 1'b0;
      W_dstE = F; W_dstM = 4'(i); W_valM = 64'h1000 + 64'(i);
    end
    @(posedge clk);
    #1;
    W_icode = 4'd1; W_dstE = F; W_dstM = F;
    for (int i = 0; i < 15; i++) begin
      d_srcA = 4'(i);
      d_srcB = 4'(14 - i);
      #1;
      check($sformatf("sweep A r%0d", i), d_rvalA, 64'h1000 + 64'(i));
      check($sformatf("sweep B r%0d", 14 - i), d_rvalB, 64'h1000 + 64'(14 - i));
      @(posedge clk);
      #1;
    end
    d_srcA = F; d_srcB = F;
    #1;
    check("rnone A", d_rvalA, 64'd0);
    check("rnone B", d_rvalB, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    check("sweep retired", retired, 64'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
